module_pc_ctrl: RTL
===================

// Module: module_pc_ctrl
// PURPOSE
//   Next-generation program-counter unit for the MIPS core fetch stage.
//   - Generalises the plain PC with selectable next-PC modes: sequential, conditional branch, call, return.
//   - Adds a stall hold and a parametrised return-address stack (RAS).
//   - Adds sticky RAS overflow/underflow status bits, to be mirrored into the status register.
// PARAMETERS
//   WORD_SIZE     32  width of PC, target and RAS entries
//   RESET_VECTOR  0   PC value loaded on reset; must be INSTR_BYTES-aligned
//   INSTR_BYTES   4   sequential increment; power of two, >=1
//   RAS_DEPTH     4   return-address stack entries; power of two, >=2
// PORTS
//   clk            in   1          single clock, all state updates on posedge
//   reset          in   1          synchronous, active-low
//   stall          in   1          1 = hold PC and RAS this cycle
//   mode           in   2          00 SEQ, 01 BRANCH, 10 CALL, 11 RET
//   branch_taken   in   1          qualifies mode BRANCH only
//   target         in   WORD_SIZE  branch/call destination, RET fallback
//   clr_err        in   1          clears sticky error bits
//   pc_out         out  WORD_SIZE  registered current PC
//   pc_next        out  WORD_SIZE  combinational value pc_out takes at next edge (reset excluded)
//   ras_empty      out  1          RAS holds 0 entries
//   ras_full       out  1          RAS holds RAS_DEPTH entries
//   ras_overflow   out  1          sticky: CALL issued while full
//   ras_underflow  out  1          sticky: RET issued while empty
// BEHAVIOUR
//   Reset (reset==0 at posedge)
//   - pc_out=RESET_VECTOR; RAS count=0 (ras_empty=1, ras_full=0); both sticky bits 0.
//   - All other inputs ignored; reset has priority over all other inputs.
//   Priority when not in reset: stall > mode.
//   - stall=1: pc_out and RAS unchanged; pc_next=pc_out; clr_err still acts.
//   Alignment and arithmetic
//   - tgt = target with low log2(INSTR_BYTES) bits forced to 0.
//   - seq = pc_out+INSTR_BYTES, truncated to WORD_SIZE (0xFFFFFFFC+4 -> 0x0).
//   Latency: mode/target sampled at posedge N; pc_out reflects them after posedge N.
//   Modes
//   - SEQ: pc<=seq.
//   - BRANCH: pc<=branch_taken ? tgt : seq.
//   - CALL: push seq; pc<=tgt.
//     - Full: circular write overwrites the oldest entry; count stays RAS_DEPTH; ras_overflow<=1.
//   - RET, not empty: pc<=top entry; pop; count-1.
//   - RET, empty: pc<=tgt; RAS unchanged; ras_underflow<=1.
//   RAS organisation
//   - Circular buffer: top pointer (log2 RAS_DEPTH bits, wraps) plus count (0..RAS_DEPTH).
//   - After overflow, RAS_DEPTH RETs return the newest RAS_DEPTH addresses; the next RET underflows.
//   Sticky bits
//   - Set only by the events above; cleared by clr_err.
//   - Set wins over clr_err in the same cycle.
//   - Not set during stall cycles.
// STRUCTURE
//   Package pc_ctrl_pkg
//   - localparams PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_CALL=2'b10, PC_RET=2'b11.
//   - Function clog2 for pointer widths.
//   Sub-module module_ras (WORD_SIZE, RAS_DEPTH)
//   - Inputs: clk, reset, push, pop, push_data.
//   - Outputs: top_data, empty, full, ovf_evt, unf_evt.
//   - push and pop are mutually exclusive by construction.
//   Top level: next-PC mux, stall gating, sticky flags.
// TESTING
//   1 Reset: reset=0 for 2 cycles with mode=CALL, target=0x100 -> pc_out=0x0, ras_empty=1, both sticky bits 0.
//   2 Wrap and alignment:
//     - BRANCH taken, target=0xFFFFFFFF -> pc=0xFFFFFFFC.
//     - Then SEQ -> pc=0x0.
//     - BRANCH not taken -> pc=0x4.
//   3 Stall: stall=1 for 3 cycles with BRANCH taken, target=0x40 -> pc_out and pc_next constant; stall=0 -> pc=0x40 next edge.
//   4 Nesting from pc=0x10:
//     - CALL 0x100, then CALL 0x200 -> pc=0x200.
//     - RET -> 0x104; RET -> 0x14; ras_empty=1.
//   5 Overflow/underflow (RAS_DEPTH=4):
//     - 5 CALLs -> ras_overflow=1, ras_full=1.
//     - 4 RETs return the last 4 pushed addresses.
//     - 5th RET with target=0x80 -> pc=0x80, ras_underflow=1.
//   6 Sticky clear:
//     - clr_err in the same cycle as an underflow RET -> bit stays 1.
//     - clr_err alone next cycle -> 0.
//     - Reset mid-sequence (RAS at 2 entries) -> pc=RESET_VECTOR, ras_empty=1.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared constants and helpers for the fetch-stage program-counter unit.
package pc_ctrl_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_CALL   = 2'b10;
  localparam logic [1:0] PC_RET    = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/module_ras.sv
// Circular return-address stack: a wrapping top pointer plus an occupancy count.
module module_ras
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] push_data,
  output logic [WORD_SIZE-1:0] top_data,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf_evt,
  output logic                 unf_evt
);

  localparam int unsigned PtrW = clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WORD_SIZE-1:0] mem_q [RAS_DEPTH];
  logic [WORD_SIZE-1:0] mem_d [RAS_DEPTH];
  logic [PtrW-1:0]      top_q, top_d, wr_ptr;
  logic [CntW-1:0]      cnt_q, cnt_d;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(RAS_DEPTH));
  assign wr_ptr   = top_q + PtrW'(1);
  assign top_data = mem_q[top_q];
  assign ovf_evt  = push & full;
  assign unf_evt  = pop & empty;

  // When full, wr_ptr lands on the oldest entry, so a push overwrites it.
  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_ptr] = push_data;
      top_d         = wr_ptr;
      if (!full) cnt_d = cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      top_d = top_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/module_pc_ctrl.sv
// Program-counter unit: next-PC mux (seq/branch/call/ret), stall hold, RAS and
// sticky RAS overflow/underflow status.
module module_pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned          WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter int unsigned          INSTR_BYTES  = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [1:0]           mode,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] target,
  input  logic                 clr_err,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [WORD_SIZE-1:0] pc_next,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_overflow,
  output logic                 ras_underflow
);

  localparam logic [WORD_SIZE-1:0] Incr      = WORD_SIZE'(INSTR_BYTES);
  localparam logic [WORD_SIZE-1:0] AlignMask = ~WORD_SIZE'(INSTR_BYTES - 1);

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [WORD_SIZE-1:0] tgt, seq, ras_top;
  logic                 push, pop, ovf_evt, unf_evt;

  assign tgt = target & AlignMask;
  assign seq = pc_q + Incr;

  module_ras #(
    .WORD_SIZE (WORD_SIZE),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf_evt   (ovf_evt),
    .unf_evt   (unf_evt)
  );

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (!stall) begin
      unique case (mode)
        PC_SEQ:    pc_d = seq;
        PC_BRANCH: pc_d = branch_taken ? tgt : seq;
        PC_CALL: begin
          push = 1'b1;
          pc_d = tgt;
        end
        PC_RET: begin
          pop  = 1'b1;
          pc_d = ras_empty ? tgt : ras_top;
        end
        default: pc_d = seq;
      endcase
    end
  end

  // A new event wins over clr_err; stalls suppress events via push/pop gating.
  always_comb begin
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    if (ovf_evt) ovf_d = 1'b1;
    if (unf_evt) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc_next       = pc_d;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
